// File: rtl/video_sync_gen_if.sv
// Video timing bundle between the sync/pattern generator and the VGA output stage.
// The master drives timing and pixel data; the slave owns the pattern controls.
interface video_sync_gen_if;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic        video_hd;
    logic        video_vd;
    logic        video_den;
    logic [23:0] video_rgb_out;
    logic [9:0]  video_x;
    logic [9:0]  video_y;
    logic        video_frame_start;

    modport master (
        input  pattern_sel,
        input  solid_rgb,
        output video_hd,
        output video_vd,
        output video_den,
        output video_rgb_out,
        output video_x,
        output video_y,
        output video_frame_start
    );

    modport slave (
        output pattern_sel,
        output solid_rgb,
        input  video_hd,
        input  video_vd,
        input  video_den,
        input  video_rgb_out,
        input  video_x,
        input  video_y,
        input  video_frame_start
    );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator (default 640x480@60) with a frame-synchronous test-pattern source.
// All outputs are registered and mutually aligned one clock after the counters they decode.
module video_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              video_clk_i,
    input  logic              video_rst_i,
    video_sync_gen_if.master  vid
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = H_ACTIVE / 8;

    // Colour-bar palette, packed {B,G,R}.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'h00FFFF;
            3'd2:    c = 24'hFFFF00;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'h0000FF;
            3'd6:    c = 24'hFF0000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [1:0]  pat_sel_q, pat_sel_d;
    logic [23:0] solid_q, solid_d;
    logic        hd_q, vd_q, den_q, fs_q;
    logic [23:0] rgb_q;
    logic [9:0]  x_q, y_q;

    logic        frame_start_s, den_s, hd_s, vd_s;
    logic [2:0]  bar_idx_s;
    logic [23:0] rgb_s;
    int          h_int_s, v_int_s;

    // Counter advance and frame-start pattern capture.
    always_comb begin
        h_int_s       = int'(h_cnt_q);
        v_int_s       = int'(v_cnt_q);
        frame_start_s = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        if (h_int_s == H_TOTAL - 1) begin
            h_cnt_d = 10'd0;
            if (v_int_s == V_TOTAL - 1) begin
                v_cnt_d = 10'd0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
            v_cnt_d = v_cnt_q;
        end
        // The frame-start pixel already uses the newly captured selection.
        if (frame_start_s) begin
            pat_sel_d = vid.pattern_sel;
            solid_d   = vid.solid_rgb;
        end else begin
            pat_sel_d = pat_sel_q;
            solid_d   = solid_q;
        end
    end

    // Sync/enable decode and pattern generation from the current counters.
    always_comb begin
        den_s = (h_int_s < H_ACTIVE) && (v_int_s < V_ACTIVE);
        hd_s  = !((h_int_s >= HS_START) && (h_int_s < HS_END));
        vd_s  = !((v_int_s >= VS_START) && (v_int_s < VS_END));
        bar_idx_s = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_int_s >= i * BAR_W) begin
                bar_idx_s = 3'(i);
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
        if (den_s) begin
            case (pat_sel_d)
                2'd0:    rgb_s = bar_colour(bar_idx_s);
                2'd1:    rgb_s = {3{h_cnt_q[7:0]}};
                2'd2:    rgb_s = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
                default: rgb_s = solid_d;
            endcase
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Counter, pattern-capture and output registers.
    always_ff @(posedge video_clk_i) begin
        if (video_rst_i) begin
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            pat_sel_q <= vid.pattern_sel;
            solid_q   <= vid.solid_rgb;
            hd_q      <= 1'b1;
            vd_q      <= 1'b1;
            den_q     <= 1'b0;
            rgb_q     <= 24'h000000;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            pat_sel_q <= pat_sel_d;
            solid_q   <= solid_d;
            hd_q      <= hd_s;
            vd_q      <= vd_s;
            den_q     <= den_s;
            rgb_q     <= rgb_s;
            x_q       <= den_s ? h_cnt_q : 10'd0;
            y_q       <= den_s ? v_cnt_q : 10'd0;
            fs_q      <= frame_start_s;
        end
    end

    assign vid.video_hd          = hd_q;
    assign vid.video_vd          = vd_q;
    assign vid.video_den         = den_q;
    assign vid.video_rgb_out     = rgb_q;
    assign vid.video_x           = x_q;
    assign vid.video_y           = y_q;
    assign vid.video_frame_start = fs_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench for video_sync_gen using a reduced raster so several frames fit in a short run.
// A behavioural raster model pushes the expected outputs for each edge; they are compared one edge later.
module tb_video_sync_gen;

    localparam int HA = 320, HF = 8, HS = 16, HB = 8;
    localparam int VA = 36,  VF = 2, VS = 2,  VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        hd;
        logic        vd;
        logic        den;
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
    } out_t;

    typedef struct packed {
        logic [1:0] sel;
        out_t       o;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_sync_gen_if vif();

    video_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .video_clk_i (clk),
        .video_rst_i (rst),
        .vid         (vif)
    );

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                              24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_h = 0, m_v = 0;
    logic [1:0]  m_sel = 2'd0;
    logic [23:0] m_solid = 24'h0;
    longint      cyc = 0, last_fs = 0;
    bit          have_fs = 1'b0, prev_was_rst = 1'b1;
    int          den_cnt = 0, vd_cnt = 0, line_pos = 0, hd_low_len = 0;
    logic        prev_den = 1'b0, prev_hd = 1'b1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        sb_t  e;
        out_t g;
        bit   was_rst;
        was_rst = rst;
        e = '0;
        if (rst) begin
            m_h = 0; m_v = 0;
            m_sel = vif.pattern_sel; m_solid = vif.solid_rgb;
            e.o.hd = 1'b1; e.o.vd = 1'b1;
        end else begin
            if (m_h == 0 && m_v == 0) begin
                m_sel = vif.pattern_sel; m_solid = vif.solid_rgb;
            end
            e.o.den = (m_h < HA) && (m_v < VA);
            e.o.hd  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
            e.o.vd  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            e.o.fs  = (m_h == 0) && (m_v == 0);
            e.o.x   = e.o.den ? 10'(m_h) : 10'd0;
            e.o.y   = e.o.den ? 10'(m_v) : 10'd0;
            if (e.o.den) begin
                case (m_sel)
                    2'd0:    e.o.rgb = bars[m_h / (HA / 8)];
                    2'd1:    e.o.rgb = {3{8'(m_h)}};
                    2'd2:    e.o.rgb = (((m_h / 32) % 2) != ((m_v / 32) % 2)) ? 24'hFFFFFF : 24'h0;
                    default: e.o.rgb = m_solid;
                endcase
            end
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v++;
                if (m_v == VT) m_v = 0;
            end
        end
        e.sel = m_sel;
        sb_q.push_back(e);

        @(negedge clk);
        cyc++;
        e = sb_q.pop_front();
        g = {vif.video_hd, vif.video_vd, vif.video_den, vif.video_rgb_out,
             vif.video_x, vif.video_y, vif.video_frame_start};
        check_val(was_rst ? "reset_out" : "pixel", g, e.o);

        // Spot checks against literal pattern values.
        if (!was_rst && e.o.den) begin
            if (e.sel == 2'd0 && e.o.y == 10'd0 && e.o.x == 10'd0)  check_val("bar_x0", g.rgb, 24'hFFFFFF);
            if (e.sel == 2'd0 && e.o.y == 10'd0 && e.o.x == 10'd40) check_val("bar_x40", g.rgb, 24'h00FFFF);
            if (e.sel == 2'd0 && e.o.y == 10'd20 && e.o.x == 10'd40) check_val("bar_line20", g.rgb, 24'h00FFFF);
            if (e.sel == 2'd1 && e.o.y == 10'd0 && e.o.x == 10'd300) check_val("ramp_x300", g.rgb, 24'h2C2C2C);
            if (e.sel == 2'd2 && e.o.y == 10'd0 && e.o.x == 10'd32)  check_val("chk_32_0", g.rgb, 24'hFFFFFF);
            if (e.sel == 2'd2 && e.o.y == 10'd32 && e.o.x == 10'd32) check_val("chk_32_32", g.rgb, 24'h000000);
            if (e.sel == 2'd3 && e.o.y == 10'd5 && e.o.x == 10'd5)   check_val("solid", g.rgb, 24'h123456);
        end

        if (was_rst) begin
            have_fs = 1'b0; line_pos = HT + 1; hd_low_len = 0;
            prev_den = 1'b0; prev_hd = 1'b1;
        end else begin
            if (prev_was_rst) begin
                check_val("first_fs", g.fs, 1'b1);
                check_val("first_den", g.den, 1'b1);
            end
            if (g.fs) begin
                if (have_fs) begin
                    check_val("fs_period", cyc - last_fs, FRAME);
                    check_val("den_per_frame", den_cnt, HA * VA);
                    check_val("vd_low_per_frame", vd_cnt, HT * VS);
                end
                have_fs = 1'b1; last_fs = cyc; den_cnt = 0; vd_cnt = 0;
            end
            den_cnt += int'(g.den);
            vd_cnt  += int'(!g.vd);
            if (g.den && !prev_den) line_pos = 0;
            else line_pos++;
            if (!g.hd && prev_hd && line_pos < HT) check_val("hd_start", line_pos, HA + HF);
            if (!g.hd) begin
                hd_low_len++;
            end else begin
                if (!prev_hd && hd_low_len > 0) check_val("hd_width", hd_low_len, HS);
                hd_low_len = 0;
            end
            prev_den = g.den;
            prev_hd  = g.hd;
        end
        prev_was_rst = was_rst;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vif.pattern_sel = 2'd0;
        vif.solid_rgb   = 24'h000000;
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        // Frame 0: bars; a mid-frame switch to solid must wait for frame 1.
        run(10 * HT);
        vif.pattern_sel = 2'd3;
        vif.solid_rgb   = 24'h123456;
        run(FRAME - 10 * HT);
        // Frame 1: solid; switch to ramp for frame 2.
        run(5 * HT);
        vif.pattern_sel = 2'd1;
        run(FRAME - 5 * HT);
        // Frame 2: ramp; switch to checkerboard for frame 3.
        run(5 * HT);
        vif.pattern_sel = 2'd2;
        run(FRAME - 5 * HT);
        // Frame 3: checkerboard, then a one-cycle reset at line 30, column 200.
        run(30 * HT + 200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(400);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_sync_gen.md
# video_sync_gen

Generates the 640x480@60 raster timing (horizontal/vertical sync, data-enable, pixel coordinates) and a selectable test-pattern RGB stream for the video output path. Sits directly upstream of the VGA timing/output stage and drives its Video_HD, Video_VD, Video_DEN and Video_RGB_Out inputs from the same Video_CLK (25.175 MHz nominal). All outputs are registered.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
- Video_CLK  in  1  pixel clock; all logic on rising edge
- Video_RST  in  1  synchronous, active-high reset
- Pattern_Sel  in  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
- Solid_RGB  in  24  colour for pattern 3, packed {B,G,R}
- Video_HD  out  1  horizontal sync, active low
- Video_VD  out  1  vertical sync, active low
- Video_DEN  out  1  high during active pixels
- Video_RGB_Out  out  24  pixel colour, B [23:16], G [15:8], R [7:0]
- Video_X  out  10  active-pixel column (0..H_ACTIVE-1), 0 outside active
- Video_Y  out  10  active-pixel row (0..V_ACTIVE-1), 0 outside active
- Video_Frame_Start  out  1  one-cycle pulse with pixel (0,0)

## Operation
- Internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1). h_cnt increments every clock; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1 on the same edge as h_cnt wrap.
- Line order: active (h_cnt 0..H_ACTIVE-1), front porch, sync, back porch. Frame order likewise for v_cnt.
- Decodes (from current counters, registered into outputs):
  - DEN = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - HD = 0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else 1.
  - VD = 0 for whole lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else 1 (changes with HD-independent line boundary, i.e. at h_cnt = 0).
  - X = h_cnt, Y = v_cnt when DEN, else 0.
  - Frame_Start = (h_cnt == 0 && v_cnt == 0).
- Pattern (when DEN; RGB = 24'h0 when DEN low):
  - 0 bars: 8 bars of width H_ACTIVE/8 (80), index by h_cnt compare: white FFFFFF, yellow 00FFFF, cyan FFFF00, green 00FF00, magenta FF00FF, red 0000FF, blue FF0000, black 000000 (values in {B,G,R}).
  - 1 ramp: B=G=R = h_cnt[7:0] (wraps every 256 px).
  - 2 checker: white if h_cnt[5] ^ v_cnt[5], else black (32x32 squares).
  - 3 solid: active-pattern solid register.
- Pattern_Sel and Solid_RGB are captured into internal registers only on the cycle h_cnt==0 && v_cnt==0 (and during reset); changes mid-frame take effect at the next frame start, never mid-frame.
- Width rules: counters 10 bits; parameters must satisfy H_TOTAL, V_TOTAL <= 1024 and H_ACTIVE divisible by 8.

## Timing
- Reset (Video_RST high at an edge): h_cnt=0, v_cnt=0, captured pattern = Pattern_Sel/Solid_RGB inputs; outputs HD=1, VD=1, DEN=0, RGB=0, X=0, Y=0, Frame_Start=0. Reset mid-frame restarts the raster at (0,0) immediately; no partial-frame completion.
- Latency: every output at edge k+1 reflects counters held during cycle k; all outputs mutually aligned (RGB, DEN, HD, VD, X, Y same cycle). First edge after reset release: DEN=1, Frame_Start=1, X=0, Y=0, RGB = pixel (0,0) of the pattern selected at reset.
- Per line: DEN high 640 clocks, HD low 96 clocks starting 656 clocks after DEN rise. Per frame: 420,000 clocks; VD low 1600 clocks starting at line 490, h_cnt 0.
- Frame_Start exactly once per 420,000 clocks.

## Test plan
- Reset release, Pattern_Sel=0 -> first output cycle DEN=1, Frame_Start=1, RGB=FFFFFF; RGB becomes 00FFFF at X=80; DEN falls after 640 cycles; HD low for cycles 656..751 of the line.
- Run 2 full frames -> Frame_Start pulses 420,000 clocks apart; VD low exactly lines 490-491 (1600 clocks); DEN high count per frame = 307,200; RGB=0 whenever DEN=0.
- Pattern_Sel=1 -> pixel X=300 gives RGB=2C2C2C; Pattern_Sel=2 -> (X=32,Y=0) white FFFFFF, (X=32,Y=32) black.
- Change Pattern_Sel 0->3 with Solid_RGB=123456 at line 100 -> rest of frame stays bars; next frame all active pixels 123456.
- Assert Video_RST for 1 cycle at line 300, X=200 -> outputs take reset values next edge; after release raster restarts at (0,0) with Frame_Start=1.
- Cross-check against downstream VGA stage: VGA_BLANK_n/HS/VS derived from these outputs show 800x525 totals with no glitches across line/frame wrap.
